clock_tick_generator: RTL and testbench

Produces every time base the stopwatch datapath consumes from the single board clock: normal count tick, adjust-mode count tick, display-refresh tick and blink square wave. Drives the clock-selection input side of the stopwatch, so every downstream register runs on `in_clock` with single-cycle enables rather than derived clocks. Owns the safe changeover between normal and adjust rate when `in_adjust` toggles.

---
 rtl/clock_tick_pkg.sv | 26 ++
 rtl/tick_divider.sv | 41 ++++
 rtl/clock_tick_generator.sv | 144 ++++++++++++++
 tb/tb_clock_tick_generator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/clock_tick_pkg.sv
// Shared types and helpers for the stopwatch time-base generator.
package clock_tick_pkg;

  // Count-rate selection FSM.
  typedef enum logic [1:0] {
    S_NORMAL,
    S_SWITCH,
    S_ADJUST
  } tick_state_t;

  localparam int unsigned DefaultClkHz     = 100_000_000;
  localparam int unsigned DefaultNormalHz  = 1;
  localparam int unsigned DefaultAdjustHz  = 2;
  localparam int unsigned DefaultDisplayHz = 500;
  localparam int unsigned DefaultBlinkHz   = 4;

  // Cycles per period of f_hz; returns 0 when the ratio is not an exact integer >= 2,
  // which the top level turns into an elaboration failure.
  function automatic int unsigned divisor(input int unsigned clk_hz, input int unsigned f_hz);
    if (f_hz == 0) return 0;
    if ((clk_hz % f_hz) != 0) return 0;
    if ((clk_hz / f_hz) < 2) return 0;
    return clk_hz / f_hz;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle registered enable.
// The enable is high for the cycle after the counter sits at DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_clear,
  output logic out_tick
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  // Wrap at DIV-1; a synchronous clear restarts the phase and drops any pending tick.
  always_comb begin
    cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CntMax);
    if (in_clear) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end
  end

  // Counter and enable registers.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign out_tick = tick_q;

endmodule

// File: rtl/clock_tick_generator.sv
// Time-base generator for the stopwatch: count, adjust, display and blink enables,
// all single-cycle enables on in_clock. Optional blink output via CLOCK_TICK_BLINK_EN.
module clock_tick_generator
  import clock_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DefaultClkHz,
  parameter int unsigned NORMAL_HZ  = DefaultNormalHz,
  parameter int unsigned ADJUST_HZ  = DefaultAdjustHz,
  parameter int unsigned DISPLAY_HZ = DefaultDisplayHz,
  parameter int unsigned BLINK_HZ   = DefaultBlinkHz
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic in_adjust,
  output logic out_tick,
  output logic out_tick_norm,
  output logic out_tick_adj,
  output logic out_display_tick,
  output logic out_blink,
  output logic out_mode
);

  localparam int unsigned DivNorm = divisor(CLK_HZ, NORMAL_HZ);
  localparam int unsigned DivAdj  = divisor(CLK_HZ, ADJUST_HZ);
  localparam int unsigned DivDisp = divisor(CLK_HZ, DISPLAY_HZ);

  if (DivNorm == 0) begin : g_bad_norm
    $fatal(1, "NORMAL_HZ must divide CLK_HZ with a divisor >= 2");
  end
  if (DivAdj == 0) begin : g_bad_adj
    $fatal(1, "ADJUST_HZ must divide CLK_HZ with a divisor >= 2");
  end
  if (DivDisp == 0) begin : g_bad_disp
    $fatal(1, "DISPLAY_HZ must divide CLK_HZ with a divisor >= 2");
  end

  logic        adj_s1_q, adj_s_q;
  tick_state_t state_q, state_d;
  logic        rate_clear;

  // Two-flop synchronizer for the asynchronous adjust switch.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      adj_s1_q <= 1'b0;
      adj_s_q  <= 1'b0;
    end else begin
      adj_s1_q <= in_adjust;
      adj_s_q  <= adj_s1_q;
    end
  end

  tick_divider #(.DIV(DivNorm)) u_div_norm (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_clear (rate_clear),
    .out_tick (out_tick_norm)
  );

  tick_divider #(.DIV(DivAdj)) u_div_adj (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_clear (rate_clear),
    .out_tick (out_tick_adj)
  );

  // Display refresh is never re-phased by a mode change.
  tick_divider #(.DIV(DivDisp)) u_div_disp (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_clear (1'b0),
    .out_tick (out_display_tick)
  );

  // Mode FSM state register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q <= S_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and tick selection; S_SWITCH masks the tick and re-phases both rate counters
  // so the first tick in the new mode lands a full period later.
  always_comb begin
    state_d    = state_q;
    rate_clear = 1'b0;
    out_tick   = 1'b0;
    out_mode   = 1'b0;
    unique case (state_q)
      S_NORMAL: begin
        out_tick = out_tick_norm;
        if (adj_s_q) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        rate_clear = 1'b1;
        out_mode   = adj_s_q;
        state_d    = adj_s_q ? S_ADJUST : S_NORMAL;
      end
      S_ADJUST: begin
        out_tick = out_tick_adj;
        out_mode = 1'b1;
        if (!adj_s_q) state_d = S_SWITCH;
      end
      default: state_d = S_NORMAL;
    endcase
  end

`ifdef CLOCK_TICK_BLINK_EN
  localparam int unsigned BlinkHalf = divisor(CLK_HZ, 2 * BLINK_HZ);
  if (BlinkHalf == 0) begin : g_bad_blink
    $fatal(1, "2*BLINK_HZ must divide CLK_HZ with a divisor >= 2");
  end
  localparam int unsigned BlinkW = $clog2(BlinkHalf);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkHalf - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  // Half-period counter; the square wave flips each time it wraps.
  always_comb begin
    blink_cnt_d = (blink_cnt_q == BlinkMax) ? '0 : blink_cnt_q + 1'b1;
    blink_d     = blink_q ^ (blink_cnt_q == BlinkMax);
  end

  // Blink registers.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign out_blink = blink_q;
`else
  logic unused_blink_hz;
  assign unused_blink_hz = ^BLINK_HZ;
  assign out_blink       = 1'b0;
`endif

endmodule

// File: tb/tb_clock_tick_generator.sv
// Directed bench for clock_tick_generator with scaled-down rates
// (D_norm=100, D_adj=20, D_disp=4, blink half-period 20).
module tb_clock_tick_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adj = 1'b0;
  logic out_tick, out_tick_norm, out_tick_adj, out_display_tick, out_blink, out_mode;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  clock_tick_generator #(
    .CLK_HZ     (1000),
    .NORMAL_HZ  (10),
    .ADJUST_HZ  (50),
    .DISPLAY_HZ (250),
    .BLINK_HZ   (25)
  ) dut (
    .in_clock         (clk),
    .in_reset         (rst),
    .in_adjust        (adj),
    .out_tick         (out_tick),
    .out_tick_norm    (out_tick_norm),
    .out_tick_adj     (out_tick_adj),
    .out_display_tick (out_display_tick),
    .out_blink        (out_blink),
    .out_mode         (out_mode)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Reset across two edges, release between edges; edge 1 is the first edge after release.
  task automatic do_reset();
    rst = 1'b1;
    adj = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    edge_n = 0;
  endtask

  // Tick expected at edge k for divisor d; sw is the edge that re-phased the counter (0: none).
  function automatic int exp_tick(input int k, input int d, input int sw);
    if (sw != 0 && k >= sw) return ((k > sw) && ((k - sw) % d == 0)) ? 1 : 0;
    return ((k > 0) && (k % d == 0)) ? 1 : 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tick"}, out_tick, 0);
    check_eq({tag, "_norm"}, out_tick_norm, 0);
    check_eq({tag, "_adj"}, out_tick_adj, 0);
    check_eq({tag, "_disp"}, out_display_tick, 0);
    check_eq({tag, "_blink"}, out_blink, 0);
    check_eq({tag, "_mode"}, out_mode, 0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    #3;
    rst = 1'b0;
    edge_n = 0;

    // Normal mode for 300 edges, plus display and blink.
    repeat (300) begin
      step();
      check_eq($sformatf("t1_tick@%0d", edge_n), out_tick, exp_tick(edge_n, 100, 0));
      check_eq($sformatf("t1_norm@%0d", edge_n), out_tick_norm, exp_tick(edge_n, 100, 0));
      check_eq($sformatf("t1_disp@%0d", edge_n), out_display_tick, exp_tick(edge_n, 4, 0));
      check_eq($sformatf("t1_mode@%0d", edge_n), out_mode, 0);
`ifdef CLOCK_TICK_BLINK_EN
      check_eq($sformatf("t1_blink@%0d", edge_n), out_blink, (edge_n / 20) % 2);
`else
      check_eq($sformatf("t1_blink@%0d", edge_n), out_blink, 0);
`endif
    end

    // Switch to adjust after edge 150: mode at 153 (S_SWITCH), counters re-phased at 154.
    do_reset();
    repeat (220) begin
      step();
      check_eq($sformatf("t2_tick@%0d", edge_n), out_tick,
               (edge_n < 154) ? exp_tick(edge_n, 100, 0) : exp_tick(edge_n, 20, 154));
      check_eq($sformatf("t2_norm@%0d", edge_n), out_tick_norm, exp_tick(edge_n, 100, 154));
      check_eq($sformatf("t2_adj@%0d", edge_n), out_tick_adj, exp_tick(edge_n, 20, 154));
      check_eq($sformatf("t2_disp@%0d", edge_n), out_display_tick, exp_tick(edge_n, 4, 0));
      check_eq($sformatf("t2_mode@%0d", edge_n), out_mode, (edge_n >= 153) ? 1 : 0);
      if (edge_n == 150) adj = 1'b1;
    end

    // S_SWITCH lands on the normal tick at edge 100: that tick and edge 101 stay low.
    do_reset();
    repeat (140) begin
      step();
      check_eq($sformatf("t3_tick@%0d", edge_n), out_tick,
               (edge_n <= 100) ? 0 : exp_tick(edge_n, 20, 101));
      check_eq($sformatf("t3_adj@%0d", edge_n), out_tick_adj, exp_tick(edge_n, 20, 101));
      check_eq($sformatf("t3_mode@%0d", edge_n), out_mode, (edge_n >= 100) ? 1 : 0);
      if (edge_n == 97) adj = 1'b1;
    end

    // One-cycle glitch: single S_SWITCH at 33, back to normal re-phased at 34, mode stays 0.
    do_reset();
    repeat (150) begin
      step();
      check_eq($sformatf("t4_tick@%0d", edge_n), out_tick, exp_tick(edge_n, 100, 34));
      check_eq($sformatf("t4_norm@%0d", edge_n), out_tick_norm, exp_tick(edge_n, 100, 34));
      check_eq($sformatf("t4_mode@%0d", edge_n), out_mode, 0);
      if (edge_n == 30) adj = 1'b1;
      if (edge_n == 31) adj = 1'b0;
    end

    // Asynchronous reset between edges while enables are high.
    do_reset();
    repeat (60) step();
    check_eq("t5_pre_disp", out_display_tick, 1);
    check_eq("t5_pre_adj", out_tick_adj, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    edge_n = 0;
    repeat (100) begin
      step();
      check_eq($sformatf("t5_tick@%0d", edge_n), out_tick, exp_tick(edge_n, 100, 0));
      check_eq($sformatf("t5_norm@%0d", edge_n), out_tick_norm, exp_tick(edge_n, 100, 0));
      check_eq($sformatf("t5_adj@%0d", edge_n), out_tick_adj, exp_tick(edge_n, 20, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
